letter_board: RTL and testbench

//  Word-scramble board engine: the responder to the game FSM. Loads a target word of
//  4/5/6 letters, shuffles it, applies player swaps and pulses isCorrect on a solve.

---
 rtl/letter_board_pkg.sv | 60 ++++++
 rtl/letter_board_rom.sv | 64 ++++++
 rtl/letter_board.sv | 176 +++++++++++++++++
 tb/tb_letter_board.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/letter_board_pkg.sv
// Shared types and constants for the word-scramble board engine.
// Contents: FSM state enum, game-state code, board geometry, letter codes,
// LFSR tap mask, and small helpers for reduction, swapping and ROM packing.
package letter_board_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHUFFLE,
        ST_CHECK,
        ST_READY,
        ST_VERIFY,
        ST_SOLVED
    } state_t;

    localparam logic [2:0] CTRL_GAME = 3'd2;
    localparam int         MAX_LEN   = 8;
    localparam int         MIN_LEN   = 4;
    localparam int         LETTER_W  = 5;
    localparam int         BOARD_W   = MAX_LEN * LETTER_W;

    localparam logic [LETTER_W-1:0] L_BLANK = 5'd0;
    localparam logic [LETTER_W-1:0] L_A     = 5'd1;
    localparam logic [LETTER_W-1:0] L_Z     = 5'd26;

    // Right-shift Galois form of x^8+x^6+x^5+x^4+1
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    typedef logic [MAX_LEN-1:0][LETTER_W-1:0] board_t;

    // Folds a 3-bit position into 0..len-1; one subtraction suffices for len >= 4.
    function automatic logic [2:0] red(input logic [2:0] v, input logic [2:0] len);
        return (v >= len) ? v - len : v;
    endfunction

    function automatic board_t swap_pos(input board_t b, input logic [2:0] a, input logic [2:0] c);
        board_t r;
        r    = b;
        r[a] = b[c];
        r[c] = b[a];
        return r;
    endfunction

    // Converts a 6-character ASCII literal (first character = position 0) into
    // letter codes; anything outside A..Z becomes blank, so words are space padded.
    function automatic board_t pack_word(input logic [47:0] s);
        board_t     w;
        logic [7:0] code;
        w = '0;
        for (int i = 0; i < 6; i++) begin
            code = s[8*(5-i) +: 8] - 8'h40;
            if (code >= {3'b000, L_A} && code <= {3'b000, L_Z})
                w[i] = LETTER_W'(code);
            else
                w[i] = L_BLANK;
        end
        return w;
    endfunction

endpackage

// File: rtl/letter_board_rom.sv
// Target word table: three lengths x eight words, purely combinational.
// Every word has distinct letters in positions 0 and 1 so that swapping
// them always breaks an accidental solve.
//   len_sel : 0/1/2 -> 4/5/6 letters (3 treated as 6)
//   idx     : word index
//   word    : 8 letter codes, position 0 in [4:0], unused positions blank
module word_rom
    import letter_board_pkg::*;
(
    input  logic [1:0]         len_sel,
    input  logic [2:0]         idx,
    output logic [BOARD_W-1:0] word
);

    logic [47:0] text;

    always_comb begin
        text = "      ";
        case (len_sel)
            2'd0: begin
                case (idx)
                    3'd0: text = "GAME  ";
                    3'd1: text = "WORD  ";
                    3'd2: text = "PLAY  ";
                    3'd3: text = "TIME  ";
                    3'd4: text = "FISH  ";
                    3'd5: text = "BOLT  ";
                    3'd6: text = "JUMP  ";
                    3'd7: text = "QUIZ  ";
                    default: text = "      ";
                endcase
            end
            2'd1: begin
                case (idx)
                    3'd0: text = "BOARD ";
                    3'd1: text = "SWAPS ";
                    3'd2: text = "LIGHT ";
                    3'd3: text = "PIANO ";
                    3'd4: text = "CLOCK ";
                    3'd5: text = "FROST ";
                    3'd6: text = "MANGO ";
                    3'd7: text = "TRAIN ";
                    default: text = "      ";
                endcase
            end
            default: begin
                case (idx)
                    3'd0: text = "PUZZLE";
                    3'd1: text = "PLANET";
                    3'd2: text = "GARDEN";
                    3'd3: text = "SILVER";
                    3'd4: text = "CASTLE";
                    3'd5: text = "ORANGE";
                    3'd6: text = "BRIDGE";
                    3'd7: text = "WINTER";
                    default: text = "      ";
                endcase
            end
        endcase
    end

    assign word = pack_word(text);

endmodule

// File: rtl/letter_board.sv
// Word-scramble board engine. Loads a 4/5/6-letter target, scrambles it with
// an LFSR, applies player swaps and pulses isCorrect on a solve. Only active
// while controlSig selects the GAME state.
//   clk, rst      : clock, synchronous active-low reset
//   controlSig    : game FSM state code
//   scramPls      : new-word request pulse
//   flipPls       : swap request pulse with positions indIn1/indIn2
//   lettNum       : word length select (0/1/2 -> 4/5/6, 3 -> 6)
//   isCorrect     : one-cycle solve pulse
//   busy          : high while swaps are not accepted
//   wordLen       : active length, 0 when idle
//   wordIdx       : ROM index of the current target
//   boardFlat     : 8 letters, position 0 in [4:0]
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | board cleared, waiting for a new-word request in GAME
// LOAD    | fetch target from ROM into board and target registers
// SHUFFLE | one random swap per cycle, down-counting cnt to 1
// CHECK   | break an accidental solve by swapping positions 0 and 1
// READY   | accepting swaps or a new-word request
// VERIFY  | compare board with target after a player swap
// SOLVED  | solve reported, reload a word of the same length
module letter_board
    import letter_board_pkg::*;
#(
    parameter int         SHUFFLE_STEPS = 16,
    parameter logic [7:0] LFSR_SEED     = 8'hA5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [2:0]         controlSig,
    input  logic               scramPls,
    input  logic               flipPls,
    input  logic [2:0]         indIn1,
    input  logic [2:0]         indIn2,
    input  logic [1:0]         lettNum,
    output logic               isCorrect,
    output logic               busy,
    output logic [3:0]         wordLen,
    output logic [2:0]         wordIdx,
    output logic [BOARD_W-1:0] boardFlat
);

    state_t     state_q, state_d;
    logic [7:0] lfsr_q, lfsr_d;
    board_t     board_q, board_d;
    board_t     target_q, target_d;
    board_t     rom_word;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] len_q, len_d;
    logic [1:0] sel_q, sel_d;
    logic [2:0] idx_q, idx_d;
    logic       busy_q, busy_d;
    logic       correct_q, correct_d;
    logic       flip_ok;
    logic [1:0] sel_in;

    word_rom u_rom (
        .len_sel (sel_q),
        .idx     (lfsr_q[2:0]),
        .word    (rom_word)
    );

    assign sel_in  = (lettNum == 2'd3) ? 2'd2 : lettNum;
    assign flip_ok = ({1'b0, indIn1} < len_q) && ({1'b0, indIn2} < len_q) && (indIn1 != indIn2);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            lfsr_q    <= LFSR_SEED;
            board_q   <= '0;
            target_q  <= '0;
            cnt_q     <= '0;
            len_q     <= '0;
            sel_q     <= '0;
            idx_q     <= '0;
            busy_q    <= 1'b0;
            correct_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            lfsr_q    <= lfsr_d;
            board_q   <= board_d;
            target_q  <= target_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            sel_q     <= sel_d;
            idx_q     <= idx_d;
            busy_q    <= busy_d;
            correct_q <= correct_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        lfsr_d    = {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 8'h00);
        board_d   = board_q;
        target_d  = target_q;
        cnt_d     = cnt_q;
        len_d     = len_q;
        sel_d     = sel_q;
        idx_d     = idx_q;
        correct_d = 1'b0;

        // Leaving GAME aborts from anywhere, including mid-scramble.
        if (state_q != ST_IDLE && controlSig != CTRL_GAME) begin
            state_d  = ST_IDLE;
            board_d  = '0;
            target_d = '0;
            len_d    = '0;
            idx_d    = '0;
            cnt_d    = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    board_d  = '0;
                    target_d = '0;
                    len_d    = '0;
                    idx_d    = '0;
                    if (scramPls && controlSig == CTRL_GAME) begin
                        sel_d   = sel_in;
                        state_d = ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    len_d    = 4'(MIN_LEN) + {2'b00, sel_q};
                    idx_d    = lfsr_q[2:0];
                    board_d  = rom_word;
                    target_d = rom_word;
                    cnt_d    = 8'(SHUFFLE_STEPS);
                    state_d  = (SHUFFLE_STEPS == 0) ? ST_CHECK : ST_SHUFFLE;
                end
                ST_SHUFFLE: begin
                    board_d = swap_pos(board_q, red(cnt_q[2:0], len_q[2:0]),
                                       red(lfsr_q[2:0], len_q[2:0]));
                    cnt_d   = cnt_q - 8'd1;
                    if (cnt_q <= 8'd1)
                        state_d = ST_CHECK;
                end
                ST_CHECK: begin
                    if (board_q == target_q)
                        board_d = swap_pos(board_q, 3'd0, 3'd1);
                    state_d = ST_READY;
                end
                ST_READY: begin
                    if (scramPls) begin
                        sel_d   = sel_in;
                        state_d = ST_LOAD;
                    end else if (flipPls && flip_ok) begin
                        board_d = swap_pos(board_q, indIn1, indIn2);
                        state_d = ST_VERIFY;
                    end
                end
                ST_VERIFY: begin
                    if (board_q == target_q) begin
                        correct_d = 1'b1;
                        state_d   = ST_SOLVED;
                    end else begin
                        state_d = ST_READY;
                    end
                end
                ST_SOLVED: state_d = ST_LOAD;
                default:   state_d = ST_IDLE;
            endcase
        end

        busy_d = !(state_d == ST_IDLE || state_d == ST_READY);
    end

    assign isCorrect = correct_q;
    assign busy      = busy_q;
    assign wordLen   = len_q;
    assign wordIdx   = idx_q;
    assign boardFlat = board_q;

endmodule

// File: tb/tb_letter_board.sv
// Directed bench for letter_board: one instance without scrambling (board
// contents fully predictable) and one with the default scramble count.
module tb_letter_board;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  controlSig = 3'd0;
    logic        scramPls = 1'b0;
    logic        flipPls = 1'b0;
    logic [2:0]  indIn1 = 3'd0;
    logic [2:0]  indIn2 = 3'd0;
    logic [1:0]  lettNum = 2'd0;

    logic        isCorrect0, busy0, isCorrect1, busy1;
    logic [3:0]  wordLen0, wordLen1;
    logic [2:0]  wordIdx0, wordIdx1;
    logic [39:0] board0, board1;

    always #5 clk = ~clk;

    letter_board #(.SHUFFLE_STEPS(0), .LFSR_SEED(8'hA5)) dut0 (
        .clk(clk), .rst(rst), .controlSig(controlSig), .scramPls(scramPls),
        .flipPls(flipPls), .indIn1(indIn1), .indIn2(indIn2), .lettNum(lettNum),
        .isCorrect(isCorrect0), .busy(busy0), .wordLen(wordLen0),
        .wordIdx(wordIdx0), .boardFlat(board0)
    );

    letter_board #(.SHUFFLE_STEPS(16), .LFSR_SEED(8'hA5)) dut1 (
        .clk(clk), .rst(rst), .controlSig(controlSig), .scramPls(scramPls),
        .flipPls(flipPls), .indIn1(indIn1), .indIn2(indIn2), .lettNum(lettNum),
        .isCorrect(isCorrect1), .busy(busy1), .wordLen(wordLen1),
        .wordIdx(wordIdx1), .boardFlat(board1)
    );

    int n_checks = 0;
    int n_errors = 0;

    string rom4[8] = '{"GAME", "WORD", "PLAY", "TIME", "FISH", "BOLT", "JUMP", "QUIZ"};
    string rom5[8] = '{"BOARD", "SWAPS", "LIGHT", "PIANO", "CLOCK", "FROST", "MANGO", "TRAIN"};
    string rom6[8] = '{"PUZZLE", "PLANET", "GARDEN", "SILVER", "CASTLE", "ORANGE", "BRIDGE", "WINTER"};

    // Reference LFSR: Galois, x^8+x^6+x^5+x^4+1, written bit by bit.
    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        logic fb;
        fb = v[0];
        return {fb, v[7], v[6] ^ fb, v[5] ^ fb, v[4] ^ fb, v[3], v[2], v[1]};
    endfunction

    logic [7:0] m;
    always @(posedge clk) begin
        if (!rst) m <= 8'hA5;
        else      m <= lfsr_next(m);
    end

    function automatic logic [39:0] enc(input string s);
        logic [39:0] w;
        byte c;
        w = '0;
        for (int i = 0; i < s.len(); i++) begin
            c = s[i];
            w[5*i +: 5] = c[4:0];
        end
        return w;
    endfunction

    function automatic logic [39:0] rom_word(input int len, input int idx);
        if (len == 4)      return enc(rom4[idx]);
        else if (len == 5) return enc(rom5[idx]);
        else               return enc(rom6[idx]);
    endfunction

    function automatic logic [39:0] swp(input logic [39:0] w, input int a, input int b);
        logic [39:0] r;
        r = w;
        r[5*a +: 5] = w[5*b +: 5];
        r[5*b +: 5] = w[5*a +: 5];
        return r;
    endfunction

    function automatic bit perm_ok(input logic [39:0] a, input logic [39:0] b);
        int ca[32];
        int cb[32];
        for (int c = 0; c < 32; c++) begin
            ca[c] = 0;
            cb[c] = 0;
        end
        for (int p = 0; p < 8; p++) begin
            ca[a[5*p +: 5]]++;
            cb[b[5*p +: 5]]++;
        end
        for (int c = 0; c < 32; c++)
            if (ca[c] != cb[c]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input bit scr, input bit flp, input logic [2:0] a, input logic [2:0] b);
        @(negedge clk);
        scramPls = scr;
        flipPls  = flp;
        indIn1   = a;
        indIn2   = b;
        @(posedge clk);
        #1;
        scramPls = 1'b0;
        flipPls  = 1'b0;
    endtask

    task automatic wait_ready(input bit which);
        int k;
        k = 0;
        while ((which ? busy1 : busy0) && k < 60) begin
            tick();
            k++;
        end
        chk("ready", which ? busy1 : busy0, 1'b0);
    endtask

    logic [7:0]  nx;
    logic [2:0]  idx;
    logic [39:0] cur;
    int          explen;

    initial begin
        // Reset state
        controlSig = 3'd2;
        lettNum    = 2'd0;
        repeat (3) tick();
        chk("rst_board", board0, 40'h0);
        chk("rst_len", wordLen0, 4'd0);
        chk("rst_busy", busy0, 1'b0);
        chk("rst_correct", isCorrect0, 1'b0);
        chk("rst_idx", wordIdx0, 3'd0);
        @(negedge clk);
        rst = 1'b1;

        // 1: request timed so the LOAD cycle sees lfsr[2:0]==0 -> "GAME"
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            nx = lfsr_next(m);
            if (nx[2:0] == 3'd0) break;
        end
        scramPls = 1'b1;
        @(posedge clk);
        #1;
        scramPls = 1'b0;
        chk("t1_busy_load", busy0, 1'b1);
        tick();
        chk("t1_busy_check", busy0, 1'b1);
        chk("t1_len", wordLen0, 4'd4);
        chk("t1_idx", wordIdx0, 3'd0);
        chk("t1_raw", board0, enc("GAME"));
        tick();
        chk("t1_busy_ready", busy0, 1'b0);
        chk("t1_board", board0, enc("AGME"));

        // 2: solving swap
        pulse(1'b0, 1'b1, 3'd0, 3'd1);
        chk("t2_board", board0, enc("GAME"));
        chk("t2_busy", busy0, 1'b1);
        chk("t2_early", isCorrect0, 1'b0);
        tick();
        chk("t2_correct", isCorrect0, 1'b1);
        chk("t2_busy_solved", busy0, 1'b1);
        tick();
        chk("t2_one_cycle", isCorrect0, 1'b0);
        chk("t2_busy_load", busy0, 1'b1);
        idx = m[2:0];
        wait_ready(1'b0);
        chk("t2_next_idx", wordIdx0, idx);
        chk("t2_next_board", board0, swp(rom_word(4, idx), 0, 1));
        chk("t2_next_len", wordLen0, 4'd4);

        // 3: invalid requests dropped, valid miss returns to READY
        cur = swp(rom_word(4, idx), 0, 1);
        pulse(1'b0, 1'b1, 3'd5, 3'd1);
        chk("t3_range_board", board0, cur);
        chk("t3_range_busy", busy0, 1'b0);
        tick();
        chk("t3_range_correct", isCorrect0, 1'b0);
        chk("t3_range_board2", board0, cur);
        pulse(1'b0, 1'b1, 3'd2, 3'd2);
        chk("t3_same_board", board0, cur);
        chk("t3_same_busy", busy0, 1'b0);
        tick();
        chk("t3_same_correct", isCorrect0, 1'b0);
        pulse(1'b0, 1'b1, 3'd2, 3'd3);
        chk("t3_miss_board", board0, swp(cur, 2, 3));
        chk("t3_miss_busy", busy0, 1'b1);
        tick();
        chk("t3_miss_correct", isCorrect0, 1'b0);
        chk("t3_miss_ready", busy0, 1'b0);

        // 4: scrambled words across all length selects
        @(negedge clk);
        controlSig = 3'd0;
        tick();
        tick();
        controlSig = 3'd2;
        for (int i = 0; i < 200; i++) begin
            lettNum = 2'(i % 4);
            explen  = (i % 4 == 3) ? 6 : (i % 4) + 4;
            pulse(1'b1, 1'b0, 3'd0, 3'd0);
            idx = m[2:0];
            wait_ready(1'b1);
            chk("t4_len", wordLen1, 4'(explen));
            chk("t4_idx", wordIdx1, idx);
            chk("t4_perm", perm_ok(board1, rom_word(explen, idx)), 1'b1);
            chk("t4_unsolved", (board1 == rom_word(explen, idx)), 1'b0);
        end

        // 5: leave GAME mid-scramble
        lettNum = 2'd1;
        pulse(1'b1, 1'b0, 3'd0, 3'd0);
        tick();
        tick();
        chk("t5_busy_shuffle", busy1, 1'b1);
        @(negedge clk);
        controlSig = 3'd3;
        tick();
        chk("t5_board", board1, 40'h0);
        chk("t5_len", wordLen1, 4'd0);
        chk("t5_busy", busy1, 1'b0);
        chk("t5_correct", isCorrect1, 1'b0);

        // 6: reset during VERIFY, then simultaneous requests in READY
        @(negedge clk);
        controlSig = 3'd2;
        lettNum    = 2'd0;
        pulse(1'b1, 1'b0, 3'd0, 3'd0);
        idx = m[2:0];
        wait_ready(1'b0);
        chk("t6_pre_board", board0, swp(rom_word(4, idx), 0, 1));
        pulse(1'b0, 1'b1, 3'd0, 3'd1);
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("t6_rst_board", board0, 40'h0);
        chk("t6_rst_len", wordLen0, 4'd0);
        chk("t6_rst_idx", wordIdx0, 3'd0);
        chk("t6_rst_busy", busy0, 1'b0);
        chk("t6_rst_correct", isCorrect0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        pulse(1'b1, 1'b0, 3'd0, 3'd0);
        idx = m[2:0];
        wait_ready(1'b0);
        cur = swp(rom_word(4, idx), 0, 1);
        pulse(1'b1, 1'b1, 3'd2, 3'd3);
        chk("t6_noswap", board0, cur);
        chk("t6_busy", busy0, 1'b1);
        chk("t6_correct", isCorrect0, 1'b0);
        idx = m[2:0];
        wait_ready(1'b0);
        chk("t6_new_idx", wordIdx0, idx);
        chk("t6_new_board", board0, swp(rom_word(4, idx), 0, 1));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
